t03_dpu_regfile: RTL and testbench

- CPU-facing memory-mapped register slave directly upstream of t03_DPUtop.
- Latches CPU writes into shadow registers and commits them atomically to the live DPU inputs (gameState, p1State/p2State, p1health/p2health, x1/y1/x2/y2, p1Left/p2Left) at a frame boundary, so one frame never mixes old and new sprite data.
- Also exposes a read-only status word: pending-commit flag and frame counter.

---
 rtl/t03_dpu_regfile.sv | 176 +++++++++++++++++
 tb/tb_t03_dpu_regfile.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/t03_dpu_regfile.sv
// CPU register slave for t03_DPUtop: shadow registers committed to the live DPU inputs on a vsync falling edge.
// Optional build macro T03_AUTO_COMMIT_EN: commit on every frame edge regardless of the pending flag.
module t03_dpu_regfile #(
  parameter logic [31:0] BASE_ADDR  = 32'hFF000000,
  parameter logic [10:0] Y_MAX      = 11'd500,
  parameter logic [3:0]  HEALTH_MAX = 4'd9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  input  logic        vsync,
  output logic [2:0]  gameState,
  output logic [1:0]  p1State,
  output logic [1:0]  p2State,
  output logic [3:0]  p1health,
  output logic [3:0]  p2health,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [10:0] x2,
  output logic [10:0] y2,
  output logic        p1Left,
  output logic        p2Left
);

`ifdef T03_AUTO_COMMIT_EN
  localparam logic AUTO_COMMIT = 1'b1;
`else
  localparam logic AUTO_COMMIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    OFF_STATE  = 3'd0,
    OFF_P1POS  = 3'd1,
    OFF_P2POS  = 3'd2,
    OFF_COMMIT = 3'd3,
    OFF_STATUS = 3'd4
  } reg_off_e;

  typedef struct packed {
    logic [2:0]  game_state;
    logic [1:0]  p1_state;
    logic [1:0]  p2_state;
    logic [3:0]  p1_health;
    logic [3:0]  p2_health;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [10:0] x2;
    logic [10:0] y2;
    logic        p1_left;
    logic        p2_left;
  } frame_regs_t;

  frame_regs_t shadow_q, shadow_d;
  frame_regs_t live_q, live_d;
  logic        pending_q, pending_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        vsync_q, vsync_d;

  logic     hit, wr_hit, rd_hit, frame_edge, do_commit;
  reg_off_e word_off;
  logic     unused_bits;

  function automatic logic [3:0] clamp_health(input logic [3:0] h);
    return (h > HEALTH_MAX) ? HEALTH_MAX : h;
  endfunction

  function automatic logic [10:0] clamp_y(input logic [10:0] y);
    return (y > Y_MAX) ? Y_MAX : y;
  endfunction

  assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
  assign word_off    = reg_off_e'(addr[4:2]);
  assign wr_hit      = hit & wen;
  assign rd_hit      = hit & ren & ~wen;
  assign frame_edge  = vsync_q & ~vsync;
  assign do_commit   = frame_edge & (pending_q | AUTO_COMMIT);
  assign unused_bits = ^{addr[1:0], wdata[31:27], wdata[3]};

  always_comb begin
    shadow_d    = shadow_q;
    live_d      = live_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    ack_d       = hit & (wen | ren);
    rdata_d     = '0;
    vsync_d     = vsync;

    // Commit copies shadow_q, so a write in this same cycle lands after the copy.
    if (frame_edge) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      pending_d   = 1'b0;
    end
    if (do_commit) begin
      live_d = shadow_q;
    end

    if (wr_hit) begin
      case (word_off)
        OFF_STATE: begin
          shadow_d.game_state = wdata[2:0];
          shadow_d.p1_state   = wdata[5:4];
          shadow_d.p2_state   = wdata[7:6];
          shadow_d.p1_health  = clamp_health(wdata[11:8]);
          shadow_d.p2_health  = clamp_health(wdata[15:12]);
          shadow_d.p1_left    = wdata[16];
          shadow_d.p2_left    = wdata[17];
        end
        OFF_P1POS: begin
          shadow_d.x1 = wdata[10:0];
          shadow_d.y1 = clamp_y(wdata[26:16]);
        end
        OFF_P2POS: begin
          shadow_d.x2 = wdata[10:0];
          shadow_d.y2 = clamp_y(wdata[26:16]);
        end
        OFF_COMMIT: pending_d = 1'b1;
        default: ;
      endcase
    end

    if (rd_hit) begin
      case (word_off)
        OFF_STATE: rdata_d = {14'b0, shadow_q.p2_left, shadow_q.p1_left,
                              shadow_q.p2_health, shadow_q.p1_health,
                              shadow_q.p2_state, shadow_q.p1_state,
                              1'b0, shadow_q.game_state};
        OFF_P1POS:  rdata_d = {5'b0, shadow_q.y1, 5'b0, shadow_q.x1};
        OFF_P2POS:  rdata_d = {5'b0, shadow_q.y2, 5'b0, shadow_q.x2};
        OFF_STATUS: rdata_d = {frame_cnt_q, 15'b0, pending_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q    <= '0;
      live_q      <= '0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      vsync_q     <= 1'b1;
    end else begin
      shadow_q    <= shadow_d;
      live_q      <= live_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      vsync_q     <= vsync_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign gameState = live_q.game_state;
  assign p1State   = live_q.p1_state;
  assign p2State   = live_q.p2_state;
  assign p1health  = live_q.p1_health;
  assign p2health  = live_q.p2_health;
  assign x1        = live_q.x1;
  assign y1        = live_q.y1;
  assign x2        = live_q.x2;
  assign y2        = live_q.y2;
  assign p1Left    = live_q.p1_left;
  assign p2Left    = live_q.p2_left;

endmodule

// File: tb/tb_t03_dpu_regfile.sv
// Bench for t03_dpu_regfile: directed vector table, hand sequences for simultaneous events, random traffic vs. a word-level model.
module tb_t03_dpu_regfile;

`ifdef T03_AUTO_COMMIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'hFF000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wen = 1'b0, ren = 1'b0, vsync = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic [2:0]  gameState;
  logic [1:0]  p1State, p2State;
  logic [3:0]  p1health, p2health;
  logic [10:0] x1, y1, x2, y2;
  logic        p1Left, p2Left;

  t03_dpu_regfile #(.BASE_ADDR(32'hFF000000), .Y_MAX(11'd500), .HEALTH_MAX(4'd9)) dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .vsync(vsync), .gameState(gameState),
    .p1State(p1State), .p2State(p2State), .p1health(p1health), .p2health(p2health),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .p1Left(p1Left), .p2Left(p2Left)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Word-level model: register images as the CPU would read them back.
  logic [31:0] m_sh [3];
  logic [31:0] m_lv [3];
  bit          m_pend;
  logic [15:0] m_cnt;
  bit          m_vs_q;
  bit          exp_ack, exp_rd_valid;
  logic [31:0] exp_rd;

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    bit          vs;
    bit          ack;
    bit          chk_rd;
    logic [31:0] rd;
    logic [63:0] live;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] clamp_state(input logic [31:0] d);
    logic [3:0] h1, h2;
    h1 = d[11:8];
    h2 = d[15:12];
    if (h1 > 4'd9) h1 = 4'd9;
    if (h2 > 4'd9) h2 = 4'd9;
    return {14'b0, d[17], d[16], h2, h1, d[7:6], d[5:4], 1'b0, d[2:0]};
  endfunction

  function automatic logic [31:0] clamp_pos(input logic [31:0] d);
    logic [10:0] y;
    y = d[26:16];
    if (y > 11'd500) y = 11'd500;
    return {5'b0, y, 5'b0, d[10:0]};
  endfunction

  function automatic logic [63:0] mk_live(input logic [2:0] gs, input logic [1:0] s1, input logic [1:0] s2,
                                          input logic [3:0] h1, input logic [3:0] h2,
                                          input logic [10:0] ax1, input logic [10:0] ay1,
                                          input logic [10:0] ax2, input logic [10:0] ay2,
                                          input logic l1, input logic l2);
    return {3'b0, gs, s1, s2, h1, h2, ax1, ay1, ax2, ay2, l1, l2};
  endfunction

  function automatic logic [63:0] model_live();
    return mk_live(m_lv[0][2:0], m_lv[0][5:4], m_lv[0][7:6], m_lv[0][11:8], m_lv[0][15:12],
                   m_lv[1][10:0], m_lv[1][26:16], m_lv[2][10:0], m_lv[2][26:16],
                   m_lv[0][16], m_lv[0][17]);
  endfunction

  function automatic logic [63:0] dut_live();
    return {3'b0, gameState, p1State, p2State, p1health, p2health, x1, y1, x2, y2, p1Left, p2Left};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sh[i] = '0;
      m_lv[i] = '0;
    end
    m_pend = 1'b0;
    m_cnt  = '0;
    m_vs_q = 1'b1;
  endtask

  task automatic model_step(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input bit vs);
    bit          hit;
    logic [31:0] word;
    hit          = (a[31:5] == BASE[31:5]);
    word         = {29'b0, a[4:2]};
    exp_ack      = hit && (w || r);
    exp_rd_valid = hit && r && !w;
    exp_rd       = '0;
    if (exp_rd_valid) begin
      case (word)
        0, 1, 2: exp_rd = m_sh[word];
        4:       exp_rd = {m_cnt, 15'b0, m_pend};
        default: exp_rd = '0;
      endcase
    end
    if (m_vs_q && !vs) begin
      m_cnt = m_cnt + 16'd1;
      if (m_pend || AUTO) begin
        for (int i = 0; i < 3; i++) m_lv[i] = m_sh[i];
      end
      m_pend = 1'b0;
    end
    if (hit && w) begin
      case (word)
        0:       m_sh[0] = clamp_state(d);
        1, 2:    m_sh[word] = clamp_pos(d);
        3:       m_pend = 1'b1;
        default: ;
      endcase
    end
    m_vs_q = vs;
  endtask

  // Called at a negedge: drive one cycle of inputs, then check the registered response.
  task automatic cycle(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input bit vs);
    wen = w; ren = r; addr = a; wdata = d; vsync = vs;
    model_step(w, r, a, d, vs);
    @(negedge clk);
    check("ack", 64'(ack), 64'(exp_ack));
    if (exp_rd_valid) check("rdata", 64'(rdata), 64'(exp_rd));
    check("live", dut_live(), model_live());
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic add(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input bit vs,
                     input bit ack_e, input bit chk, input logic [31:0] rd_e, input logic [63:0] live_e);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.d = d; v.vs = vs;
    v.ack = ack_e; v.chk_rd = chk; v.rd = rd_e; v.live = live_e;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b0; wen = 1'b0; ren = 1'b0; vsync = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [63:0] l0, lc, lx;
    logic [31:0] ra, rd;
    bit          rw, rr, rv;

    l0 = '0;
    lc = mk_live(3'd5, 2'd0, 2'd1, 4'd9, 4'd2, 11'd320, 11'd500, 11'd0, 11'd0, 1'b1, 1'b1);
`ifdef T03_AUTO_COMMIT_EN
    lx = lc;
`else
    lx = l0;
`endif
    add(0, 1, 32'hFF000010, 0,            1, 1, 1, 32'h0,          l0);
    add(1, 0, 32'hFF000000, 32'h00032A45, 1, 1, 0, 32'h0,          l0);
    add(0, 1, 32'hFF000000, 0,            1, 1, 1, 32'h00032945,   l0);
    add(1, 0, 32'hFF000004, 32'h02580140, 1, 1, 0, 32'h0,          l0);
    add(0, 1, 32'hFF000004, 0,            1, 1, 1, 32'h01F40140,   l0);
    add(1, 0, 32'hFF000040, 32'hFFFFFFFF, 1, 0, 0, 32'h0,          l0);
    add(1, 0, 32'hFF000014, 32'hFFFFFFFF, 1, 1, 0, 32'h0,          l0);
    add(0, 1, 32'hFF000014, 0,            1, 1, 1, 32'h0,          l0);
    add(0, 0, 32'h0,        0,            0, 0, 0, 32'h0,          lx);
    add(0, 0, 32'h0,        0,            1, 0, 0, 32'h0,          lx);
    add(1, 0, 32'hFF00000C, 0,            1, 1, 0, 32'h0,          lx);
    add(0, 1, 32'hFF000010, 0,            1, 1, 1, 32'h00010001,   lx);
    add(0, 0, 32'h0,        0,            0, 0, 0, 32'h0,          lc);
    add(0, 1, 32'hFF000010, 0,            1, 1, 1, 32'h00020000,   lc);
    add(1, 1, 32'hFF000000, 0,            1, 1, 0, 32'h0,          lc);
    add(0, 1, 32'hFF000003, 0,            1, 1, 1, 32'h0,          lc);
    add(0, 1, 32'hFF00001C, 0,            1, 1, 1, 32'h0,          lc);
    add(0, 1, 32'hFF000048, 0,            1, 0, 0, 32'h0,          lc);

    do_reset();
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_live", dut_live(), 64'd0);

    foreach (tbl[i]) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].vs);
      check($sformatf("tbl%0d_ack", i), 64'(ack), 64'(tbl[i].ack));
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(tbl[i].rd));
      check($sformatf("tbl%0d_live", i), dut_live(), tbl[i].live);
    end

    // COMMIT write coinciding with a frame edge
    cycle(1, 0, 32'hFF000000, 32'h00000003, 1);
    cycle(1, 0, 32'hFF00000C, 0, 0);
    check("commit_on_edge_gs", 64'(gameState), AUTO ? 64'd3 : 64'd5);
    cycle(0, 1, 32'hFF000010, 0, 1);
    check("commit_on_edge_pending", 64'(rdata), 64'h00030001);
    cycle(0, 0, 32'h0, 0, 0);
    check("deferred_commit_gs", 64'(gameState), 64'd3);
    cycle(0, 1, 32'hFF000010, 0, 1);
    check("deferred_commit_status", 64'(rdata), 64'h00040000);

    // shadow write coinciding with a frame edge
    cycle(1, 0, 32'hFF000000, 32'h00000006, 1);
    cycle(1, 0, 32'hFF00000C, 0, 1);
    cycle(1, 0, 32'hFF000000, 32'h00000001, 0);
    check("write_on_edge_old", 64'(gameState), 64'd6);
    cycle(1, 0, 32'hFF00000C, 0, 1);
    cycle(0, 0, 32'h0, 0, 0);
    check("write_on_edge_new", 64'(gameState), 64'd1);

    // frame edge without COMMIT
    cycle(1, 0, 32'hFF000004, 32'h00140064, 1);
    cycle(0, 0, 32'h0, 0, 0);
    check("nocommit_x1", 64'(x1), AUTO ? 64'd100 : 64'd320);
    check("nocommit_y1", 64'(y1), AUTO ? 64'd20 : 64'd500);
    cycle(0, 0, 32'h0, 0, 1);

    // reset sampled on the same edge as a write strobe
    rst = 1'b0; wen = 1'b1; addr = 32'hFF000000; wdata = 32'h00000005; vsync = 1'b1;
    @(negedge clk);
    check("midreset_ack", 64'(ack), 64'd0);
    check("midreset_live", dut_live(), 64'd0);
    check("midreset_rdata", 64'(rdata), 64'd0);
    rst = 1'b1; wen = 1'b0;
    model_reset();
    cycle(0, 1, 32'hFF000000, 0, 1);
    check("midreset_shadow", 64'(rdata), 64'd0);

    for (int i = 0; i < 700; i++) begin
      cycle(0, 0, 32'h0, 0, 0);
      cycle(0, 0, 32'h0, 0, 1);
    end
    cycle(0, 1, 32'hFF000010, 0, 1);
    check("frame_cnt_700", 64'(rdata), 64'h02BC0000);

    for (int i = 0; i < 3000; i++) begin
      rw = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) ra = $urandom();
      else ra = BASE | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ra = BASE | 32'h0000000C;
      rd = $urandom();
      rv = ($urandom_range(0, 3) != 0);
      cycle(rw, rr, ra, rd, rv);
    end
    cycle(0, 1, 32'hFF000010, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
